// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RISC-V control units: FSM states, opcodes,
// immediate-extender selects, ALU-class codes and datapath mux selects.
package riscv_ctrl_pkg;

    // Multicycle controller states; the numeric values are visible on the debug port.
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StAluWb    = 4'd7,
        StExecI    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10,
        StFault    = 4'd11
    } ctrl_state_e;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    // Immediate-extender selects
    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    // ALU class: add for address/PC arithmetic, subtract for compare, funct-decoded otherwise
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    // ALU operand A sources
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARd1   = 2'b10;

    // ALU operand B sources
    localparam logic [1:0] SrcBRd2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    // Result mux sources
    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    // States that stall on the memory handshake
    function automatic logic is_wait_state(input ctrl_state_e s);
        return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Immediate-format select from the major opcode. Purely combinational so the
// single-cycle and multicycle controllers can share it.
module imm_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] immsrc
);

    // Opcode to immediate format; unknown opcodes fall back to I-type
    always_comb begin
        immsrc = ImmI;
        case (op)
            OpLoad, OpIType: immsrc = ImmI;
            OpStore:         immsrc = ImmS;
            OpBranch:        immsrc = ImmB;
            OpJal:           immsrc = ImmJ;
            default:         immsrc = ImmI;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM with memory-handshake stalls, a wait timeout
// that parks the controller in a sticky FAULT state, and an optional retired
// instruction counter enabled by defining MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  immsrc,
    output logic [1:0]  alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  resultsrc,
    output logic [1:0]  aluop,
    output logic        adrsrc,
    output logic        irwrite,
    output logic        pcwrite,
    output logic        regwrite,
    output logic        memwrite,
    output logic        fault,
    output logic [3:0]  state
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0] retired
`endif
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e       state_q, state_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CntW-1:0]   wait_cnt_inc;
    logic              mem_wait;
    logic              timeout;

    logic              ir_en, pc_update, branch, reg_en, mem_en;

    imm_decode u_imm_decode (
        .op     (op),
        .immsrc (immsrc)
    );

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next state; a ready handshake always wins over an expiring wait count
    always_comb begin
        state_d      = state_q;
        mem_wait     = is_wait_state(state_q) && !mem_ready;
        wait_cnt_inc = wait_cnt_q + 1'b1;
        timeout      = mem_wait && (wait_cnt_inc == CntW'(MEM_TIMEOUT));
        wait_cnt_d   = (mem_wait && !timeout) ? wait_cnt_inc : '0;

        unique case (state_q)
            StFetch:    if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIType:         state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpBranch:        state_d = StBeq;
                    default:         state_d = StFault;
                endcase
            end
            StMemAdr:   state_d = (op == OpStore) ? StMemWrite : StMemRead;
            StMemRead:  if (mem_ready) state_d = StMemWb;
            StMemWrite: if (mem_ready) state_d = StFetch;
            StExecR,
            StExecI:    state_d = StAluWb;
            StMemWb,
            StAluWb,
            StJal,
            StBeq:      state_d = StFetch;
            StFault:    state_d = StFault;
            default:    state_d = StFault;
        endcase

        if (timeout) begin
            state_d = StFault;
        end
    end

    // Per-state datapath selects and raw strobes; everything else stays 0
    always_comb begin
        alusrca   = SrcAPc;
        alusrcb   = SrcBRd2;
        resultsrc = ResAluOut;
        aluop     = AluOpAdd;
        adrsrc    = 1'b0;
        ir_en     = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        reg_en    = 1'b0;
        mem_en    = 1'b0;

        unique case (state_q)
            StFetch: begin
                alusrcb   = SrcBFour;
                resultsrc = ResAluResult;
                ir_en     = mem_ready;
                pc_update = mem_ready;
            end
            StDecode: begin
                alusrca = SrcAOldPc;
                alusrcb = SrcBImm;
            end
            StMemAdr: begin
                alusrca = SrcARd1;
                alusrcb = SrcBImm;
            end
            StMemRead: begin
                adrsrc = 1'b1;
            end
            StMemWb: begin
                resultsrc = ResData;
                reg_en    = 1'b1;
            end
            StMemWrite: begin
                adrsrc = 1'b1;
                mem_en = 1'b1;
            end
            StExecR: begin
                alusrca = SrcARd1;
                aluop   = AluOpFunct;
            end
            StExecI: begin
                alusrca = SrcARd1;
                alusrcb = SrcBImm;
                aluop   = AluOpFunct;
            end
            StAluWb: begin
                reg_en = 1'b1;
            end
            StJal: begin
                alusrca   = SrcAOldPc;
                alusrcb   = SrcBFour;
                pc_update = 1'b1;
            end
            StBeq: begin
                alusrca = SrcARd1;
                aluop   = AluOpSub;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset so FETCH cannot fire while rst_n is held low
    assign irwrite  = ir_en & rst_n;
    assign pcwrite  = (pc_update | (branch & zero)) & rst_n;
    assign regwrite = reg_en & rst_n;
    assign memwrite = mem_en & rst_n;
    assign fault    = (state_q == StFault);
    assign state    = state_q;

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    logic [31:0] retired_q;
    logic        retire;

    assign retire = (state_d == StFetch) &&
                    (state_q inside {StMemWb, StAluWb, StMemWrite, StJal, StBeq});

    // Retired-instruction count; wraps naturally at 32 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus process pushes the
// hand-written expected control word for each cycle; a negedge monitor pops
// and compares. The retired counter is checked when MULTICYCLE_CTRL_RETIRE_CNT_EN
// is defined.
module tb_multicycle_ctrl;

    // Control word layout: alusrca, alusrcb, resultsrc, aluop, adrsrc, irwrite,
    // pcwrite, regwrite, memwrite, fault
    localparam logic [13:0] CFetchWait = 14'b00_10_10_00_000000;
    localparam logic [13:0] CFetchGo   = 14'b00_10_10_00_011000;
    localparam logic [13:0] CDecode    = 14'b01_01_00_00_000000;
    localparam logic [13:0] CMemAdr    = 14'b10_01_00_00_000000;
    localparam logic [13:0] CMemRead   = 14'b00_00_00_00_100000;
    localparam logic [13:0] CMemWb     = 14'b00_00_01_00_000100;
    localparam logic [13:0] CMemWrite  = 14'b00_00_00_00_100010;
    localparam logic [13:0] CExecR     = 14'b10_00_00_10_000000;
    localparam logic [13:0] CExecI     = 14'b10_01_00_10_000000;
    localparam logic [13:0] CAluWb     = 14'b00_00_00_00_000100;
    localparam logic [13:0] CJal       = 14'b01_10_00_00_001000;
    localparam logic [13:0] CBeqTaken  = 14'b10_00_00_01_001000;
    localparam logic [13:0] CBeqNot    = 14'b10_00_00_01_000000;
    localparam logic [13:0] CFault     = 14'b00_00_00_00_000001;

    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpI    = 7'b0010011;
    localparam logic [6:0] OpJ    = 7'b1101111;
    localparam logic [6:0] OpB    = 7'b1100011;
    localparam logic [6:0] OpBad  = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic        zero;
    logic        mem_ready;
    logic [1:0]  immsrc, alusrca, alusrcb, resultsrc, aluop;
    logic        adrsrc, irwrite, pcwrite, regwrite, memwrite, fault;
    logic [3:0]  state;
    logic [13:0] ctl_act;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [1:0]  imm;
        logic [13:0] ctl;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_ret  = '0;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .immsrc    (immsrc),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .resultsrc (resultsrc),
        .aluop     (aluop),
        .adrsrc    (adrsrc),
        .irwrite   (irwrite),
        .pcwrite   (pcwrite),
        .regwrite  (regwrite),
        .memwrite  (memwrite),
        .fault     (fault),
        .state     (state)
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        ,
        .retired   (retired)
`endif
    );

    always #5 clk = ~clk;

    assign ctl_act = {alusrca, alusrcb, resultsrc, aluop,
                      adrsrc, irwrite, pcwrite, regwrite, memwrite, fault};

    // Monitor: one expectation per falling edge
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (state == e.st && immsrc == e.imm && ctl_act == e.ctl) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got state=%0d immsrc=%b ctl=%b, want state=%0d immsrc=%b ctl=%b",
                         e.tag, state, immsrc, ctl_act, e.st, e.imm, e.ctl);
            end
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
            n_checks++;
            if (retired == e.ret) begin
                n_pass++;
            end else begin
                $display("FAIL %s_retired: got %h, want %h", e.tag, retired, e.ret);
            end
`endif
        end
    end

    task automatic step(input string tag, input logic [6:0] o, input logic mr, input logic z,
                        input logic [3:0] st, input logic [1:0] imm, input logic [13:0] ctl);
        exp_t e;
        op        = o;
        mem_ready = mr;
        zero      = z;
        e.tag = tag;
        e.st  = st;
        e.imm = imm;
        e.ctl = ctl;
        e.ret = exp_ret;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Hold reset for one cycle with mem_ready high: FETCH strobes must stay off
    task automatic do_reset(input string tag);
        exp_t e;
        rst_n     = 1'b0;
        op        = OpSw;
        mem_ready = 1'b1;
        zero      = 1'b1;
        exp_ret   = '0;
        e.tag = tag;
        e.st  = 4'd0;
        e.imm = 2'b01;
        e.ctl = CFetchWait;
        e.ret = exp_ret;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        op        = OpBad;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset("reset");

        // R-type, I-type, jal
        step("r_fetch",  OpR, 1'b1, 1'b0, 4'd0, 2'b00, CFetchGo);
        step("r_decode", OpR, 1'b1, 1'b0, 4'd1, 2'b00, CDecode);
        step("r_exec",   OpR, 1'b1, 1'b0, 4'd6, 2'b00, CExecR);
        step("r_aluwb",  OpR, 1'b1, 1'b0, 4'd7, 2'b00, CAluWb);
        exp_ret = 32'd1;
        step("i_fetch",  OpI, 1'b1, 1'b0, 4'd0, 2'b00, CFetchGo);
        step("i_decode", OpI, 1'b1, 1'b0, 4'd1, 2'b00, CDecode);
        step("i_exec",   OpI, 1'b1, 1'b0, 4'd8, 2'b00, CExecI);
        step("i_aluwb",  OpI, 1'b1, 1'b0, 4'd7, 2'b00, CAluWb);
        exp_ret = 32'd2;
        step("j_fetch",  OpJ, 1'b1, 1'b0, 4'd0, 2'b11, CFetchGo);
        step("j_decode", OpJ, 1'b1, 1'b0, 4'd1, 2'b11, CDecode);
        step("j_jal",    OpJ, 1'b1, 1'b0, 4'd9, 2'b11, CJal);
        exp_ret = 32'd3;

        // lw with mem_ready tied high
        step("lw_fetch",   OpLw, 1'b1, 1'b0, 4'd0, 2'b00, CFetchGo);
        step("lw_decode",  OpLw, 1'b1, 1'b0, 4'd1, 2'b00, CDecode);
        step("lw_memadr",  OpLw, 1'b1, 1'b0, 4'd2, 2'b00, CMemAdr);
        step("lw_memread", OpLw, 1'b1, 1'b0, 4'd3, 2'b00, CMemRead);
        step("lw_memwb",   OpLw, 1'b1, 1'b0, 4'd4, 2'b00, CMemWb);
        exp_ret = 32'd4;

        // beq taken then not taken
        step("beq1_fetch",  OpB, 1'b1, 1'b1, 4'd0,  2'b10, CFetchGo);
        step("beq1_decode", OpB, 1'b1, 1'b1, 4'd1,  2'b10, CDecode);
        step("beq1_beq",    OpB, 1'b1, 1'b1, 4'd10, 2'b10, CBeqTaken);
        exp_ret = 32'd5;
        step("beq0_fetch",  OpB, 1'b1, 1'b0, 4'd0,  2'b10, CFetchGo);
        step("beq0_decode", OpB, 1'b1, 1'b0, 4'd1,  2'b10, CDecode);
        step("beq0_beq",    OpB, 1'b1, 1'b0, 4'd10, 2'b10, CBeqNot);
        exp_ret = 32'd6;

        // sw with three stalled MEMWRITE cycles
        step("sw_fetch",  OpSw, 1'b1, 1'b0, 4'd0, 2'b01, CFetchGo);
        step("sw_decode", OpSw, 1'b1, 1'b0, 4'd1, 2'b01, CDecode);
        step("sw_memadr", OpSw, 1'b1, 1'b0, 4'd2, 2'b01, CMemAdr);
        for (int i = 0; i < 3; i++) begin
            step("sw_stall", OpSw, 1'b0, 1'b0, 4'd5, 2'b01, CMemWrite);
        end
        step("sw_done", OpSw, 1'b1, 1'b0, 4'd5, 2'b01, CMemWrite);
        exp_ret = 32'd7;

        // 15 stalled FETCH cycles, ready on the 16th, then illegal opcode
        for (int i = 0; i < 15; i++) begin
            step("fwait15", OpBad, 1'b0, 1'b0, 4'd0, 2'b00, CFetchWait);
        end
        step("fwait_ready16", OpBad, 1'b1, 1'b0, 4'd0, 2'b00, CFetchGo);
        step("bad_decode",    OpBad, 1'b1, 1'b0, 4'd1, 2'b00, CDecode);
        for (int i = 0; i < 20; i++) begin
            step("bad_fault", OpBad, 1'(i % 2), 1'b1, 4'd11, 2'b00, CFault);
        end
        do_reset("fault_reset");

        // 16 stalled FETCH cycles time out into FAULT
        for (int i = 0; i < 16; i++) begin
            step("fwait16", OpBad, 1'b0, 1'b0, 4'd0, 2'b00, CFetchWait);
        end
        step("timeout_fault",  OpBad, 1'b0, 1'b1, 4'd11, 2'b00, CFault);
        step("timeout_sticky", OpBad, 1'b1, 1'b1, 4'd11, 2'b00, CFault);
        do_reset("timeout_reset");

        // Reset in the middle of a stalled store abandons it
        step("mid_fetch",  OpSw, 1'b1, 1'b0, 4'd0, 2'b01, CFetchGo);
        step("mid_decode", OpSw, 1'b1, 1'b0, 4'd1, 2'b01, CDecode);
        step("mid_memadr", OpSw, 1'b1, 1'b0, 4'd2, 2'b01, CMemAdr);
        step("mid_memwr",  OpSw, 1'b0, 1'b0, 4'd5, 2'b01, CMemWrite);
        do_reset("mid_reset");

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
        // Counter wrap: preload all-ones, retire one jal
        dut.retired_q = 32'hFFFF_FFFF;
        exp_ret = 32'hFFFF_FFFF;
        step("wrap_fetch",  OpJ, 1'b1, 1'b0, 4'd0, 2'b11, CFetchGo);
        step("wrap_decode", OpJ, 1'b1, 1'b0, 4'd1, 2'b11, CDecode);
        step("wrap_jal",    OpJ, 1'b1, 1'b0, 4'd9, 2'b11, CJal);
        exp_ret = 32'd0;
        step("wrap_after",  OpJ, 1'b0, 1'b0, 4'd0, 2'b11, CFetchWait);
`endif

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, the maximum number of wait cycles for mem_ready before a fault.
REQ-002 SHALL have port clk  input  1  the rising-edge system clock.
REQ-003 SHALL have port rst_n  input  1  the reset: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port op  input  7  instr[6:0] from the instruction register.
REQ-005 SHALL have port zero  input  1  the ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  the memory access-complete handshake.
REQ-007 SHALL have port immsrc  output  2  the immediate-extender select: 00 I, 01 S, 10 B, 11 J.
REQ-008 SHALL have ports alusrca, alusrcb, resultsrc, aluop  output  2 each  the datapath mux and ALU-class selects.
REQ-009 SHALL have ports adrsrc, irwrite, pcwrite, regwrite, memwrite, fault  output  1 each  the strobes and the sticky fault flag.
REQ-010 SHALL have port state  output  4  the current FSM state, for debug.

Function
REQ-011 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, FAULT=11.
REQ-012 SHALL decode immsrc combinationally from op in every state: 0000011/0010011 give 00; 0100011 gives 01; 1100011 gives 10; 1101111 gives 11; any other op gives 00.
REQ-013 SHALL transition DECODE as follows: lw/sw go to MEMADR; 0110011 goes to EXECR; 0010011 goes to EXECI; 1101111 goes to JAL; 1100011 goes to BEQ; any other op goes to FAULT.
REQ-014 SHALL transition MEMADR to MEMREAD for lw and to MEMWRITE for sw.
REQ-015 SHALL transition MEMREAD to MEMWB, and EXECR/EXECI to ALUWB.
REQ-016 SHALL transition MEMWB, ALUWB, MEMWRITE, JAL and BEQ to FETCH.
REQ-017 SHALL hold FETCH, MEMREAD and MEMWRITE until mem_ready=1; it SHALL advance on the first cycle in which mem_ready=1.
REQ-018 SHALL, in FETCH, drive adrsrc=0, alusrca=00, alusrcb=10, aluop=00 and resultsrc=10; it SHALL assert irwrite and the pcupdate term only in the cycle mem_ready=1.
REQ-019 SHALL, in DECODE, drive alusrca=01, alusrcb=01 and aluop=00.
REQ-020 SHALL, in MEMADR, drive alusrca=10, alusrcb=01 and aluop=00.
REQ-021 SHALL, in MEMREAD, drive adrsrc=1 and resultsrc=00.
REQ-022 SHALL, in MEMWB, drive resultsrc=01 and regwrite=1.
REQ-023 SHALL, in MEMWRITE, drive adrsrc=1 and resultsrc=00, and assert memwrite in every cycle of the state.
REQ-024 SHALL, in EXECR, drive alusrca=10, alusrcb=00 and aluop=10; in EXECI, alusrca=10, alusrcb=01 and aluop=10.
REQ-025 SHALL, in ALUWB, drive resultsrc=00 and regwrite=1.
REQ-026 SHALL, in JAL, drive alusrca=01, alusrcb=10, aluop=00, resultsrc=00 and pcupdate=1.
REQ-027 SHALL, in BEQ, drive alusrca=10, alusrcb=00, aluop=01, resultsrc=00 and branch=1.
REQ-028 SHALL compute pcwrite = pcupdate OR (branch AND zero).
REQ-029 SHALL drive all outputs not listed for a state to 0.
REQ-030 SHALL count consecutive mem_ready=0 cycles in a wait state and clear the count on state exit.
REQ-031 SHALL go to FAULT when the wait count reaches MEM_TIMEOUT while mem_ready=0; mem_ready=1 in that same cycle takes priority over the timeout.
REQ-032 SHALL keep FAULT absorbing until reset, with fault=1 and all strobes 0.

Reset
REQ-033 SHALL, on rst_n=0 (asynchronous), force state=FETCH, clear the wait counter, set fault=0 and hold all strobes at 0 while rst_n=0.
REQ-034 SHALL begin FETCH strobes in the first clk edge after rst_n deasserts; a reset mid-instruction SHALL abandon that instruction without a further regwrite or memwrite.

Configuration
REQ-035 SHALL, when MULTICYCLE_CTRL_RETIRE_CNT_EN is defined, add output retired (32 bits, reset 0) that increments by 1 on every transition into FETCH from MEMWB, ALUWB, MEMWRITE, JAL or BEQ, and wraps from 0xFFFFFFFF to 0.
REQ-036 SHALL, when MULTICYCLE_CTRL_RETIRE_CNT_EN is undefined, have no retired port and no counter logic.

Structure
REQ-037 SHALL place the state encodings, opcode constants, immsrc codes and the aluop codes in the shared package riscv_ctrl_pkg.
REQ-038 SHALL implement the immsrc decode as sub-module imm_decode (op in, immsrc out), reusable by the single-cycle control.

Verification
REQ-039 SHALL test lw with mem_ready tied high: the sequence is FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; regwrite=1 only in MEMWB; immsrc=00.
REQ-040 SHALL test beq with zero=1, then zero=0: pcwrite=1 in BEQ only for zero=1; immsrc=10.
REQ-041 SHALL test sw with mem_ready low for 3 cycles in MEMWRITE: memwrite=1 for 4 cycles, then FETCH.
REQ-042 SHALL test op=0000000: DECODE to FAULT, fault=1, and no strobes for 20 cycles; then pulse rst_n: state=0 and fault=0.
REQ-043 SHALL test mem_ready held low in FETCH: FAULT after MEM_TIMEOUT=16 cycles; mem_ready=1 on the 16th cycle still goes to DECODE.
REQ-044 SHALL test, with the macro defined, 3 instructions (R, I, jal): retired=3; with the counter preloaded to 0xFFFFFFFF, one retire gives 0.
